// File: rtl/if_else_dp_scheduler.sv
// if_else_dp_scheduler
// Round-robin front end that time-shares one if/else datapath between two
// job requesters. Each accepted job drives the datapath operand pins for LAT
// cycles. The combined result is then captured and held until the consumer
// takes it, and it is returned tagged with the id of the requester that issued it.
module if_else_dp_scheduler #(
    parameter int unsigned DW    = 32,
    parameter int unsigned LAT   = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [DW-1:0]    r0_bit,
    input  logic [DW-1:0]    r0_ref,
    input  logic [DW-1:0]    r0_ref_m,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [DW-1:0]    r1_bit,
    input  logic [DW-1:0]    r1_ref,
    input  logic [DW-1:0]    r1_ref_m,

    output logic [DW-1:0]    dp_input_bit,
    output logic [DW-1:0]    dp_array_ref,
    output logic [DW-1:0]    dp_array_ref_m,
    input  logic [DW-1:0]    dp_result,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic             out_id,

    output logic             busy,
    output logic [CNT_W-1:0] job_count
);

    // Wait counter only has to hold LAT-1.
    localparam int unsigned   CW       = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    logic          last_grant;   // id of the requester granted most recently
    logic          job_id;       // id of the job currently in flight
    logic [CW-1:0] cnt;

    logic          grant0;
    logic          grant1;
    logic          accept;
    logic          capture;
    logic          retire;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration, next-state selection and per-edge event strobes.
    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        retire     = 1'b0;
        case (state)
            S_IDLE: begin
                if (r0_valid && r1_valid) begin
                    // On contention the requester not granted last time wins.
                    grant0 = last_grant;
                    grant1 = !last_grant;
                end else begin
                    grant0 = r0_valid;
                    grant1 = r1_valid;
                end
                accept = grant0 | grant1;
                if (accept) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    capture    = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    retire     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand launch, latency countdown, result capture and job counting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_input_bit   <= '0;
            dp_array_ref   <= '0;
            dp_array_ref_m <= '0;
            last_grant     <= 1'b1;
            job_id         <= 1'b0;
            cnt            <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_id         <= 1'b0;
            job_count      <= '0;
        end else begin
            if (accept) begin
                if (grant1) begin
                    dp_input_bit   <= r1_bit;
                    dp_array_ref   <= r1_ref;
                    dp_array_ref_m <= r1_ref_m;
                end else begin
                    dp_input_bit   <= r0_bit;
                    dp_array_ref   <= r0_ref;
                    dp_array_ref_m <= r0_ref_m;
                end
                last_grant <= grant1;
                job_id     <= grant1;
                cnt        <= CNT_LOAD;
            end else if (state == S_WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            if (capture) begin
                out_data  <= dp_result;
                out_id    <= job_id;
                out_valid <= 1'b1;
            end

            if (retire) begin
                out_valid <= 1'b0;
                job_count <= job_count + 1'b1;
            end
        end
    end

    assign r0_ready = (state == S_IDLE) & grant0;
    assign r1_ready = (state == S_IDLE) & grant1;
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_if_else_dp_scheduler.sv
// Testbench for if_else_dp_scheduler: table-driven arbitration sequence,
// hand-written corner sequences, and randomized traffic checked against a
// transaction-level reference model.
module tb_if_else_dp_scheduler;

    localparam int unsigned DW    = 32;
    localparam int unsigned LAT   = 2;
    localparam int unsigned CNT_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0;

    // Main instance: LAT=2, narrow counter to exercise wrap.
    logic             r0_valid = 1'b0, r1_valid = 1'b0, out_ready = 1'b0;
    logic             r0_ready, r1_ready, out_valid, out_id, busy;
    logic [DW-1:0]    r0_bit = '0, r0_ref = '0, r0_ref_m = '0;
    logic [DW-1:0]    r1_bit = '0, r1_ref = '0, r1_ref_m = '0;
    logic [DW-1:0]    dp_input_bit, dp_array_ref, dp_array_ref_m, dp_result, out_data;
    logic [CNT_W-1:0] job_count;

    // Second instance: LAT=1, default counter width.
    logic             b_r0_valid = 1'b0, b_r1_valid = 1'b0, b_out_ready = 1'b0;
    logic             b_r0_ready, b_r1_ready, b_out_valid, b_out_id, b_busy;
    logic [DW-1:0]    b_r0_bit = '0, b_r0_ref = '0, b_r0_ref_m = '0;
    logic [DW-1:0]    b_r1_bit = '0, b_r1_ref = '0, b_r1_ref_m = '0;
    logic [DW-1:0]    b_dp_input_bit, b_dp_array_ref, b_dp_array_ref_m, b_dp_result, b_out_data;
    logic [15:0]      b_job_count;

    int n_checks = 0;
    int n_errors = 0;

    // Datapath function used by both behavioural datapaths and the model.
    function automatic logic [DW-1:0] dp_func(input logic [DW-1:0] c,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        return ((c != '0) ? a : b) + (c << 3);
    endfunction

    // Two-cycle datapath: result reflects operands registered one edge earlier.
    logic [DW-1:0] dp_q = '0;
    always @(posedge clk) dp_q <= dp_func(dp_input_bit, dp_array_ref, dp_array_ref_m);
    assign dp_result = dp_q;

    // One-cycle datapath: combinational.
    assign b_dp_result = dp_func(b_dp_input_bit, b_dp_array_ref, b_dp_array_ref_m);

    if_else_dp_scheduler #(.DW(DW), .LAT(LAT), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_bit(r0_bit), .r0_ref(r0_ref), .r0_ref_m(r0_ref_m),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_bit(r1_bit), .r1_ref(r1_ref), .r1_ref_m(r1_ref_m),
        .dp_input_bit(dp_input_bit), .dp_array_ref(dp_array_ref), .dp_array_ref_m(dp_array_ref_m),
        .dp_result(dp_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
        .busy(busy), .job_count(job_count)
    );

    if_else_dp_scheduler #(.DW(DW), .LAT(1), .CNT_W(16)) u_dut_lat1 (
        .clk(clk), .reset(reset),
        .r0_valid(b_r0_valid), .r0_ready(b_r0_ready), .r0_bit(b_r0_bit), .r0_ref(b_r0_ref), .r0_ref_m(b_r0_ref_m),
        .r1_valid(b_r1_valid), .r1_ready(b_r1_ready), .r1_bit(b_r1_bit), .r1_ref(b_r1_ref), .r1_ref_m(b_r1_ref_m),
        .dp_input_bit(b_dp_input_bit), .dp_array_ref(b_dp_array_ref), .dp_array_ref_m(b_dp_array_ref_m),
        .dp_result(b_dp_result),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_id(b_out_id),
        .busy(b_busy), .job_count(b_job_count)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        r0_valid = 1'b0; r1_valid = 1'b0; out_ready = 1'b0;
        b_r0_valid = 1'b0; b_r1_valid = 1'b0; b_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst job_count", 32'(job_count), 32'd0);
        chk("rst out_data", out_data, '0);
        chk("rst dp_input_bit", dp_input_bit, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // One uncontended job on the main instance, checking grant, latency and result.
    task automatic run_job(input logic who, input logic [DW-1:0] c,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
        int unsigned k;
        out_ready = 1'b1;
        if (who) begin
            r1_valid = 1'b1; r1_bit = c; r1_ref = a; r1_ref_m = b;
        end else begin
            r0_valid = 1'b1; r0_bit = c; r0_ref = a; r0_ref_m = b;
        end
        k = 0;
        @(negedge clk);
        while (!(who ? r1_ready : r0_ready) && k < 20) begin
            next_cycle();
            @(negedge clk);
            k++;
        end
        chk("job grant", 32'(who ? r1_ready : r0_ready), 32'd1);
        next_cycle();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 20) begin
            next_cycle();
            @(negedge clk);
            k++;
        end
        chk("job latency", 32'(k), 32'(LAT));
        chk("job out_data", out_data, dp_func(c, a, b));
        chk("job out_id", 32'(out_id), 32'(who));
        next_cycle();
    endtask

    // Arbitration table from reset. Field order of the packed record:
    // r0v r1v ordy | exp r0_ready r1_ready out_valid out_id busy | exp job_count
    typedef struct packed {
        logic             r0v;
        logic             r1v;
        logic             ordy;
        logic             e_r0rdy;
        logic             e_r1rdy;
        logic             e_ov;
        logic             e_id;
        logic             e_busy;
        logic [CNT_W-1:0] e_cnt;
    } vec_t;

    vec_t tbl[18];

    task automatic run_table();
        logic [DW-1:0] exp_data;
        tbl[0]  = {8'b111_10000, 4'd0};
        tbl[1]  = {8'b011_00001, 4'd0};
        tbl[2]  = {8'b011_00001, 4'd0};
        tbl[3]  = {8'b011_00101, 4'd0};
        tbl[4]  = {8'b011_01000, 4'd1};
        tbl[5]  = {8'b111_00001, 4'd1};
        tbl[6]  = {8'b111_00001, 4'd1};
        tbl[7]  = {8'b110_00111, 4'd1};
        tbl[8]  = {8'b111_00111, 4'd1};
        tbl[9]  = {8'b111_10000, 4'd2};
        tbl[10] = {8'b011_00001, 4'd2};
        tbl[11] = {8'b011_00001, 4'd2};
        tbl[12] = {8'b011_00101, 4'd2};
        tbl[13] = {8'b011_01000, 4'd3};
        tbl[14] = {8'b001_00001, 4'd3};
        tbl[15] = {8'b001_00001, 4'd3};
        tbl[16] = {8'b001_00111, 4'd3};
        tbl[17] = {8'b001_00000, 4'd4};
        r0_bit = 32'h0000_0001; r0_ref = 32'hA5A5_0000; r0_ref_m = 32'h0000_1234;
        r1_bit = 32'h0000_0000; r1_ref = 32'hDEAD_BEEF; r1_ref_m = 32'hCAFE_F00D;
        for (int i = 0; i < 18; i++) begin
            r0_valid  = tbl[i].r0v;
            r1_valid  = tbl[i].r1v;
            out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("tbl[%0d] r0_ready", i), 32'(r0_ready), 32'(tbl[i].e_r0rdy));
            chk($sformatf("tbl[%0d] r1_ready", i), 32'(r1_ready), 32'(tbl[i].e_r1rdy));
            chk($sformatf("tbl[%0d] out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("tbl[%0d] busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl[%0d] job_count", i), 32'(job_count), 32'(tbl[i].e_cnt));
            if (tbl[i].e_ov) begin
                exp_data = tbl[i].e_id ? dp_func(r1_bit, r1_ref, r1_ref_m)
                                       : dp_func(r0_bit, r0_ref, r0_ref_m);
                chk($sformatf("tbl[%0d] out_id", i), 32'(out_id), 32'(tbl[i].e_id));
                chk($sformatf("tbl[%0d] out_data", i), out_data, exp_data);
            end
            next_cycle();
        end
    endtask

    // Randomized traffic checked against a transaction-level model that tracks
    // pending requests, the in-flight job's accept cycle and the held result.
    task automatic random_phase(input int unsigned ncyc);
        logic             pend[2];
        logic [DW-1:0]    pc[2], pa[2], pb[2];
        logic             m_in_flight, m_have_out, m_last, m_id, m_out_id;
        logic             idle, any, win;
        logic [DW-1:0]    m_c, m_a, m_b, m_out_data;
        logic [CNT_W-1:0] m_count;
        int unsigned      m_acc;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; pc[i] = '0; pa[i] = '0; pb[i] = '0;
        end
        m_in_flight = 1'b0; m_have_out = 1'b0; m_last = 1'b1; m_id = 1'b0;
        m_out_id = 1'b0; m_c = '0; m_a = '0; m_b = '0; m_out_data = '0;
        m_count = '0; m_acc = 0;
        for (int unsigned cyc = 0; cyc < ncyc; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 45) begin
                    pend[i] = 1'b1;
                    pc[i] = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
                    pa[i] = $urandom;
                    pb[i] = $urandom;
                end else if (pend[i] && $urandom_range(0, 99) < 4) begin
                    pend[i] = 1'b0;
                end
            end
            r0_valid = pend[0]; r0_bit = pc[0]; r0_ref = pa[0]; r0_ref_m = pb[0];
            r1_valid = pend[1]; r1_bit = pc[1]; r1_ref = pa[1]; r1_ref_m = pb[1];
            out_ready = ($urandom_range(0, 99) < 60);
            @(negedge clk);
            idle = !m_in_flight && !m_have_out;
            any  = pend[0] | pend[1];
            win  = (pend[0] && pend[1]) ? !m_last : pend[1];
            chk("rnd r0_ready", 32'(r0_ready), 32'(idle && any && !win));
            chk("rnd r1_ready", 32'(r1_ready), 32'(idle && any && win));
            chk("rnd busy", 32'(busy), 32'(!idle));
            chk("rnd out_valid", 32'(out_valid), 32'(m_have_out));
            chk("rnd job_count", 32'(job_count), 32'(m_count));
            chk("rnd dp_input_bit", dp_input_bit, m_c);
            chk("rnd dp_array_ref", dp_array_ref, m_a);
            chk("rnd dp_array_ref_m", dp_array_ref_m, m_b);
            if (m_have_out) begin
                chk("rnd out_data", out_data, m_out_data);
                chk("rnd out_id", 32'(out_id), 32'(m_out_id));
            end
            if (m_have_out && out_ready) begin
                m_have_out = 1'b0;
                m_count++;
            end else if (m_in_flight && cyc == m_acc + LAT) begin
                m_have_out  = 1'b1;
                m_out_data  = dp_func(m_c, m_a, m_b);
                m_out_id    = m_id;
                m_in_flight = 1'b0;
            end
            if (idle && any) begin
                m_c = pc[win]; m_a = pa[win]; m_b = pb[win];
                m_in_flight = 1'b1;
                m_acc  = cyc;
                m_last = win;
                m_id   = win;
                pend[win] = 1'b0;
            end
            next_cycle();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // LAT=1 instance: one-cycle latency, dp pins change only on accept.
        do_reset();
        @(negedge clk);
        chk("lat1 rst dp_array_ref", b_dp_array_ref, '0);
        chk("lat1 rst job_count", 32'(b_job_count), 32'd0);
        next_cycle();
        b_r1_valid = 1'b1; b_r1_bit = 32'h5; b_r1_ref = 32'h1357_9BDF; b_r1_ref_m = 32'h2468_ACE0;
        b_out_ready = 1'b0;
        @(negedge clk);
        chk("lat1 r1_ready", 32'(b_r1_ready), 32'd1);
        chk("lat1 r0_ready idle", 32'(b_r0_ready), 32'd0);
        next_cycle();
        b_r1_valid = 1'b0;
        b_r0_valid = 1'b1; b_r0_bit = 32'h0; b_r0_ref = 32'h0BAD_F00D; b_r0_ref_m = 32'h7777_0001;
        @(negedge clk);
        chk("lat1 dp_input_bit", b_dp_input_bit, 32'h5);
        chk("lat1 dp_array_ref", b_dp_array_ref, 32'h1357_9BDF);
        chk("lat1 dp_array_ref_m", b_dp_array_ref_m, 32'h2468_ACE0);
        chk("lat1 out_valid wait", 32'(b_out_valid), 32'd0);
        chk("lat1 r0_ready wait", 32'(b_r0_ready), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("lat1 out_valid", 32'(b_out_valid), 32'd1);
        chk("lat1 out_data", b_out_data, dp_func(32'h5, 32'h1357_9BDF, 32'h2468_ACE0));
        chk("lat1 out_id", 32'(b_out_id), 32'd1);
        chk("lat1 r0_ready hold", 32'(b_r0_ready), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("lat1 dp held in hold", b_dp_array_ref, 32'h1357_9BDF);
        chk("lat1 out_valid held", 32'(b_out_valid), 32'd1);
        b_out_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("lat1 out_valid drop", 32'(b_out_valid), 32'd0);
        chk("lat1 job_count 1", 32'(b_job_count), 32'd1);
        chk("lat1 r0_ready idle2", 32'(b_r0_ready), 32'd1);
        chk("lat1 dp held in idle", b_dp_array_ref, 32'h1357_9BDF);
        next_cycle();
        b_r0_valid = 1'b0;
        @(negedge clk);
        chk("lat1 dp after accept", b_dp_array_ref, 32'h0BAD_F00D);
        chk("lat1 out_valid wait2", 32'(b_out_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("lat1 out_data 2", b_out_data, dp_func(32'h0, 32'h0BAD_F00D, 32'h7777_0001));
        chk("lat1 out_id 2", 32'(b_out_id), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("lat1 job_count 2", 32'(b_job_count), 32'd2);
        next_cycle();

        // Arbitration order from reset, twice.
        do_reset();
        run_table();

        // Stall in HOLD: outputs stable, no ready, single count on release.
        r0_valid = 1'b1; r0_bit = 32'h7; r0_ref = 32'h1111_0000; r0_ref_m = 32'h2222_0000;
        r1_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("hold accept r0_ready", 32'(r0_ready), 32'd1);
        next_cycle();
        r1_valid = 1'b1;
        repeat (LAT) begin
            @(negedge clk);
            chk("hold wait out_valid", 32'(out_valid), 32'd0);
            chk("hold wait r1_ready", 32'(r1_ready), 32'd0);
            next_cycle();
        end
        repeat (5) begin
            @(negedge clk);
            chk("hold out_valid", 32'(out_valid), 32'd1);
            chk("hold out_data", out_data, dp_func(32'h7, 32'h1111_0000, 32'h2222_0000));
            chk("hold out_id", 32'(out_id), 32'd0);
            chk("hold r0_ready", 32'(r0_ready), 32'd0);
            chk("hold r1_ready", 32'(r1_ready), 32'd0);
            chk("hold busy", 32'(busy), 32'd1);
            chk("hold job_count", 32'(job_count), 32'd4);
            next_cycle();
        end
        out_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("hold release out_valid", 32'(out_valid), 32'd0);
        chk("hold release job_count", 32'(job_count), 32'd5);
        chk("hold fairness r1_ready", 32'(r1_ready), 32'd1);
        chk("hold fairness r0_ready", 32'(r0_ready), 32'd0);
        next_cycle();

        // Reset in WAIT: job discarded, nothing emitted, next job normal.
        do_reset();
        r0_valid = 1'b1; r0_bit = '1; r0_ref = 32'h0F0F_0F0F; r0_ref_m = 32'h1111_2222;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rstwait accept", 32'(r0_ready), 32'd1);
        next_cycle();
        r0_valid = 1'b0;
        #1;
        chk("rstwait busy before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("rstwait dp_input_bit", dp_input_bit, '0);
        chk("rstwait dp_array_ref", dp_array_ref, '0);
        chk("rstwait dp_array_ref_m", dp_array_ref_m, '0);
        chk("rstwait out_valid", 32'(out_valid), 32'd0);
        chk("rstwait out_data", out_data, '0);
        chk("rstwait out_id", 32'(out_id), 32'd0);
        chk("rstwait busy", 32'(busy), 32'd0);
        chk("rstwait job_count", 32'(job_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("rstwait no out_valid", 32'(out_valid), 32'd0);
            chk("rstwait idle", 32'(busy), 32'd0);
            next_cycle();
        end
        run_job(1'b0, 32'h3, 32'h4444_5555, 32'h6666_7777);
        @(negedge clk);
        chk("rstwait count after job", 32'(job_count), 32'd1);
        next_cycle();

        // Counter wrap: 17 jobs on a 4-bit counter.
        do_reset();
        for (int j = 0; j < 17; j++) begin
            run_job(1'(j % 2), $urandom, $urandom, $urandom);
            @(negedge clk);
            chk($sformatf("wrap job_count after %0d", j + 1), 32'(job_count), 32'((j + 1) % 16));
            next_cycle();
        end

        // Randomized traffic.
        do_reset();
        random_phase(1500);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
